// File: rtl/mcdf_fmt_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcdf_fmt_receiver_pkg
// Description : Shared types and constants for the MCDF formatter receiver.
//               - rx_state_e  : receive FSM states
//               - ERR_*       : error codes reported on err_code_o
//               - ENTRY_W     : buffer entry width {chid[1:0], last, data[31:0]}
//               - rx_entry_t  : packed view of one buffer entry
// Revision    : 1.0 - initial release
// ============================================================================
package mcdf_fmt_receiver_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT      = 2'd1,
    S_WAIT_START = 2'd2,
    S_RECV       = 2'd3
  } rx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN_BAD = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_FRAMING = 2'd3;

  localparam int ENTRY_W = 35;

  typedef struct packed {
    logic [1:0]  chid;
    logic        last;
    logic [31:0] data;
  } rx_entry_t;

endpackage
`default_nettype wire

// File: rtl/mcdf_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mcdf_rx_buffer
// Description : Packet buffer with a speculative write pointer. Words are
//               written at wr_ptr; commit_i publishes everything written so
//               far (including a same-cycle write) to the reader; rollback_i
//               discards the uncommitted words. The read port is first-word
//               fall-through with a registered data stage.
// Ports       : clk_i, rstn_i       clock, asynchronous active-low reset
//               wr_en_i, wr_data_i  speculative write
//               commit_i            publish written words (incl. this cycle)
//               rollback_i          drop uncommitted words (wins over write)
//               free_o              DEPTH - committed occupancy
//               rd_valid_o/ready_i  read handshake, rd_data_o read word
// Revision    : 1.0 - initial release
// ============================================================================
module mcdf_rx_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 35
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          commit_i,
  input  logic          rollback_i,
  output logic [AW:0]   free_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [W-1:0]  rd_data_o
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   wr_commit_q, wr_commit_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          w_pop;
  logic          w_bypass;

  assign rd_valid_o = (rd_ptr_q != wr_commit_q);
  assign w_pop      = rd_valid_o & rd_ready_i;
  assign free_o     = (AW+1)'(DEPTH) - (wr_commit_q - rd_ptr_q);
  // Only committed words are ever presented; the data stage is zeroed otherwise.
  assign rd_data_o  = rd_valid_o ? rd_data_q : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (rollback_i) begin
      wr_ptr_d = wr_commit_q;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    wr_commit_d = wr_commit_q;
    if (commit_i) begin
      wr_commit_d = wr_en_i ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    end

    rd_ptr_d = w_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // The data stage tracks the entry the reader will look at next cycle.
    // A same-cycle write to that slot is forwarded so a freshly committed
    // single word is visible immediately.
    w_bypass  = wr_en_i && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
    rd_data_d = w_bypass ? wr_data_i : mem_q[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mcdf_fmt_receiver.sv
`default_nettype none
// ============================================================================
// Module      : mcdf_fmt_receiver
// Description : Far-end sink of the MCDF formatter interface. Grants a
//               request only when the whole packet fits in committed free
//               space, captures the start..end burst, checks framing and
//               length, commits good packets and replays them on a
//               valid/ready stream tagged with the channel id. Bad packets
//               are rolled back atomically.
// Ports       : clk_i, rstn_i                   clock, async active-low reset
//               fmt_req_i/chid_i/length_i       packet request
//               fmt_grant_o                     one-cycle grant pulse
//               fmt_data_i/start_i/end_i        packet burst
//               rx_valid_o/ready_i/data_o/chid_o/last_o  output stream
//               err_o, err_code_o, err_clr_i    sticky first-error report
// Config      : MCDF_RX_STATS_EN adds pkt_cnt_o (good packets per chid 0..2,
//               wrapping) and drop_cnt_o (discarded packets, saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module mcdf_fmt_receiver #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        fmt_req_i,
  input  logic [1:0]  fmt_chid_i,
  input  logic [5:0]  fmt_length_i,
  output logic        fmt_grant_o,
  input  logic [31:0] fmt_data_i,
  input  logic        fmt_start_i,
  input  logic        fmt_end_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic [1:0]  rx_chid_o,
  output logic        rx_last_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  input  logic        err_clr_i
`ifdef MCDF_RX_STATS_EN
  ,
  output logic [3*16-1:0] pkt_cnt_o,
  output logic [15:0]     drop_cnt_o
`endif
);

  import mcdf_fmt_receiver_pkg::*;

  localparam int          TW  = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  rx_state_e      state_q, state_d;
  logic [1:0]     chid_q, chid_d;
  logic [AW:0]    len_q, len_d;
  logic [AW:0]    beat_q, beat_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           grant_q, grant_d;
  logic           err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;

  logic [AW:0]    w_len_req;
  logic [AW:0]    w_beat_cur;
  logic [AW:0]    w_free;
  logic           w_wr_en, w_commit, w_rollback;
  logic           w_frame_err, w_done;
  logic           w_new_err;
  logic [1:0]     w_new_code;
  logic           w_pkt_good, w_pkt_drop;
  rx_entry_t      w_wr_entry, w_rd_entry;
  logic [ENTRY_W-1:0] w_rd_raw;

  assign w_len_req  = (AW+1)'(fmt_length_i);
  // Beat number of the word on fmt_data_i this cycle (1-based).
  assign w_beat_cur = (state_q == S_RECV) ? (beat_q + ONE) : ONE;
  assign w_wr_entry = '{chid: chid_q, last: (w_beat_cur == len_q), data: fmt_data_i};

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    chid_d      = chid_q;
    len_d       = len_q;
    beat_d      = beat_q;
    timer_d     = timer_q;
    grant_d     = 1'b0;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_rollback  = 1'b0;
    w_frame_err = 1'b0;
    w_done      = 1'b0;
    w_new_err   = 1'b0;
    w_new_code  = ERR_NONE;
    w_pkt_good  = 1'b0;
    w_pkt_drop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fmt_req_i) begin
          if ((w_len_req == '0) || (w_len_req > (AW+1)'(DEPTH))) begin
            w_new_err  = 1'b1;
            w_new_code = ERR_LEN_BAD;
          end else if (w_free >= w_len_req) begin
            chid_d  = fmt_chid_i;
            len_d   = w_len_req;
            state_d = S_GRANT;
          end
        end
      end

      S_GRANT: begin
        // grant_q is registered, so the pulse appears in the first WAIT_START cycle.
        grant_d = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (fmt_start_i) begin
          w_wr_en = 1'b1;
          beat_d  = ONE;
          if (len_q == ONE) begin
            if (fmt_end_i) w_done = 1'b1;
            else           w_frame_err = 1'b1;
          end else if (fmt_end_i) begin
            w_frame_err = 1'b1;
          end else begin
            state_d = S_RECV;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          w_new_err  = 1'b1;
          w_new_code = ERR_TIMEOUT;
          w_pkt_drop = 1'b1;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_RECV: begin
        w_wr_en = 1'b1;
        beat_d  = w_beat_cur;
        if (fmt_start_i) begin
          w_frame_err = 1'b1;
        end else if (w_beat_cur == len_q) begin
          if (fmt_end_i) w_done = 1'b1;
          else           w_frame_err = 1'b1;
        end else if (fmt_end_i) begin
          w_frame_err = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Rollback overrides the same-cycle write inside the buffer.
    if (w_frame_err) begin
      w_rollback = 1'b1;
      w_new_err  = 1'b1;
      w_new_code = ERR_FRAMING;
      w_pkt_drop = 1'b1;
      state_d    = S_IDLE;
    end
    if (w_done) begin
      w_commit   = 1'b1;
      w_pkt_good = 1'b1;
      state_d    = S_IDLE;
    end
  end

  // Sticky first error; a clear in the same cycle as a new error wins.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (err_clr_i) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end else if (w_new_err && !err_q) begin
      err_d      = 1'b1;
      err_code_d = w_new_code;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      chid_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      timer_q    <= '0;
      grant_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      chid_q     <= chid_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      timer_q    <= timer_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign fmt_grant_o = grant_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

  // --------------------------------------------------------------------------
  // Packet buffer
  // --------------------------------------------------------------------------
  mcdf_rx_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_buffer (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wr_en_i    (w_wr_en),
    .wr_data_i  (w_wr_entry),
    .commit_i   (w_commit),
    .rollback_i (w_rollback),
    .free_o     (w_free),
    .rd_valid_o (rx_valid_o),
    .rd_ready_i (rx_ready_i),
    .rd_data_o  (w_rd_raw)
  );

  assign w_rd_entry = rx_entry_t'(w_rd_raw);
  assign rx_data_o  = w_rd_entry.data;
  assign rx_chid_o  = w_rd_entry.chid;
  assign rx_last_o  = w_rd_entry.last;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef MCDF_RX_STATS_EN
  logic [15:0] drop_cnt_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_pkt_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        cnt_q <= '0;
      end else if (w_pkt_good && (chid_q == 2'(gi))) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign pkt_cnt_o[gi*16 +: 16] = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt_q <= '0;
    end else if (w_pkt_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
  assign drop_cnt_o = drop_cnt_q;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_pkt_good ^ w_pkt_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcdf_fmt_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcdf_fmt_receiver
// Description : Directed self-checking bench for mcdf_fmt_receiver. A small
//               formatter model issues requests and bursts; a scoreboard queue
//               holds the words of good packets in send order.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mcdf_fmt_receiver;

  typedef logic [34:0] ent_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fmt_req = 1'b0;
  logic [1:0]  fmt_chid = '0;
  logic [5:0]  fmt_len = '0;
  logic        fmt_grant;
  logic [31:0] fmt_data = '0;
  logic        fmt_start = 1'b0;
  logic        fmt_end = 1'b0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [31:0] rx_data;
  logic [1:0]  rx_chid;
  logic        rx_last;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr = 1'b0;
`ifdef MCDF_RX_STATS_EN
  logic [47:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   w_id  = 0;
  int   lat;
  logic seen;
  ent_t exp_q[$];
  ent_t head;

  always #5 clk = ~clk;

  mcdf_fmt_receiver dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .fmt_req_i    (fmt_req),
    .fmt_chid_i   (fmt_chid),
    .fmt_length_i (fmt_len),
    .fmt_grant_o  (fmt_grant),
    .fmt_data_i   (fmt_data),
    .fmt_start_i  (fmt_start),
    .fmt_end_i    (fmt_end),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .rx_data_o    (rx_data),
    .rx_chid_o    (rx_chid),
    .rx_last_o    (rx_last),
    .err_o        (err),
    .err_code_o   (err_code),
    .err_clr_i    (err_clr)
`ifdef MCDF_RX_STATS_EN
    ,
    .pkt_cnt_o    (pkt_cnt),
    .drop_cnt_o   (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and return the number of cycles until the grant pulse (-1 if none).
  task automatic do_req(input logic [1:0] c, input logic [5:0] l, input int max_t, output int lt);
    fmt_req  = 1'b1;
    fmt_chid = c;
    fmt_len  = l;
    lt = -1;
    for (int t = 1; t <= max_t; t++) begin
      tick();
      if (fmt_grant) begin
        lt = t;
        break;
      end
    end
    fmt_req = 1'b0;
  endtask

  // Drive nb beats after dly idle cycles; end flag on beat endb (0 = never).
  task automatic burst(input logic [1:0] c, input int len, input int dly,
                       input int nb, input int endb, input bit good);
    repeat (dly) tick();
    for (int b = 1; b <= nb; b++) begin
      fmt_start = (b == 1);
      fmt_end   = (b == endb);
      fmt_data  = 32'hA500_0000 + 32'(w_id) * 32'h0001_0001;
      w_id++;
      if (good) exp_q.push_back({c, (b == len), fmt_data});
      tick();
    end
    fmt_start = 1'b0;
    fmt_end   = 1'b0;
    fmt_data  = '0;
  endtask

  task automatic drain(input int n, input int budget);
    int   got = 0;
    int   cyc = 0;
    ent_t e;
    rx_ready = 1'b1;
    while (got < n && cyc < budget) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", {31'd0, rx_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e[31:0]);
          chk("rx_last", {31'd0, rx_last}, {31'd0, e[32]});
          chk("rx_chid", {30'd0, rx_chid}, {30'd0, e[34:33]});
        end
        got++;
      end
      tick();
      cyc++;
    end
    rx_ready = 1'b0;
    chk("drain_count", got, n);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {31'd0, fmt_grant}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", rx_data, 32'd0);
    chk("rst_err", {29'd0, err, err_code}, 32'd0);
    rstn = 1'b1;
    tick();

    // ---------------- basic packet: len 8, chid 1 ----------------
    do_req(2'd1, 6'd8, 10, lat);
    chk("grant_lat", lat, 32'd2);
    tick();
    chk("grant_pulse", {31'd0, fmt_grant}, 32'd0);
    burst(2'd1, 8, 1, 8, 8, 1'b1);
    chk("pkt1_valid", {31'd0, rx_valid}, 32'd1);
    drain(8, 40);
    chk("pkt1_empty", {31'd0, rx_valid}, 32'd0);
    chk("pkt1_err", {31'd0, err}, 32'd0);

    // ---------------- fill 56 words, free-space gating ----------------
    for (int p = 0; p < 7; p++) begin
      do_req(2'(p % 3), 6'd8, 10, lat);
      chk("fill_lat", lat, 32'd2);
      burst(2'(p % 3), 8, 0, 8, 8, 1'b1);
    end
    fmt_req = 1'b1; fmt_chid = 2'd2; fmt_len = 6'd16;
    seen = 1'b0;
    repeat (6) begin tick(); seen |= fmt_grant; end
    chk("free8_no_grant", {31'd0, seen}, 32'd0);
    drain(8, 40);
    lat = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (fmt_grant) begin lat = t; break; end
    end
    fmt_req = 1'b0;
    chk("grant_after_drain", lat, 32'd2);
    burst(2'd2, 16, 0, 16, 16, 1'b1);
    // Buffer now holds exactly DEPTH committed words.
    fmt_req = 1'b1; fmt_chid = 2'd0; fmt_len = 6'd1;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= fmt_grant; end
    fmt_req = 1'b0;
    chk("full_no_grant", {31'd0, seen}, 32'd0);
    drain(64, 200);
    chk("fill_empty", {31'd0, rx_valid}, 32'd0);

    // ---------------- timeout ----------------
    do_req(2'd0, 6'd4, 10, lat);
    chk("to_grant_lat", lat, 32'd2);
    repeat (15) tick();
    chk("to_not_yet", {31'd0, err}, 32'd0);
    tick();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_code", {30'd0, err_code}, 32'd2);
    chk("to_no_rx", {31'd0, rx_valid}, 32'd0);
    clear_err();
    do_req(2'd0, 6'd1, 10, lat);
    chk("to_next_lat", lat, 32'd2);
    burst(2'd0, 1, 0, 1, 1, 1'b1);
    do_req(2'd3, 6'd4, 10, lat);
    chk("chid3_lat", lat, 32'd2);
    burst(2'd3, 4, 2, 4, 4, 1'b1);
    drain(5, 40);

    // ---------------- framing errors ----------------
    do_req(2'd1, 6'd8, 10, lat);
    chk("fr_lat", lat, 32'd2);
    burst(2'd1, 8, 0, 5, 5, 1'b0);
    repeat (3) begin fmt_data = 32'hDEAD_0000 + 32'(w_id); w_id++; tick(); end
    fmt_data = '0;
    chk("fr_err", {31'd0, err}, 32'd1);
    chk("fr_code", {30'd0, err_code}, 32'd3);
    chk("fr_no_rx", {31'd0, rx_valid}, 32'd0);
    fmt_req = 1'b1; fmt_len = 6'd0;
    tick(); tick();
    chk("first_err_kept", {30'd0, err_code}, 32'd3);
    // Clear and a new LEN_BAD in the same cycle: clear wins.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_wins", {31'd0, err}, 32'd0);
    tick();
    chk("lenbad_code", {30'd0, err_code}, 32'd1);
    chk("lenbad_no_grant", {31'd0, fmt_grant}, 32'd0);
    fmt_req = 1'b0;
    clear_err();
    // Missing end on the final beat.
    do_req(2'd0, 6'd3, 10, lat);
    burst(2'd0, 3, 0, 3, 0, 1'b0);
    chk("noend_code", {30'd0, err_code}, 32'd3);
    clear_err();
    do_req(2'd2, 6'd4, 10, lat);
    chk("fr_good_lat", lat, 32'd2);
    burst(2'd2, 4, 0, 4, 4, 1'b1);
    drain(4, 40);

    // ---------------- backpressure across commit and wrap ----------------
    do_req(2'd1, 6'd8, 10, lat);
    burst(2'd1, 8, 0, 8, 8, 1'b1);
    head = exp_q[0];
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", {31'd0, rx_valid}, 32'd1);
      chk("hold_data", rx_data, head[31:0]);
      tick();
    end
    do_req(2'd2, 6'd8, 10, lat);
    chk("bp_lat", lat, 32'd2);
    fork
      burst(2'd2, 8, 1, 8, 8, 1'b1);
      drain(16, 100);
    join
    chk("bp_empty", {31'd0, rx_valid}, 32'd0);

    // ---------------- reset in the middle of a packet ----------------
    fmt_req = 1'b1; fmt_len = 6'd0;
    tick(); tick();
    fmt_req = 1'b0;
    chk("pre_rst_err", {31'd0, err}, 32'd1);
    do_req(2'd0, 6'd8, 10, lat);
    burst(2'd0, 8, 0, 3, 0, 1'b0);
    rstn = 1'b0;
    #2;
    chk("mid_rst_grant", {31'd0, fmt_grant}, 32'd0);
    chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_rst_data", {rx_data[31:3], rx_chid, rx_last}, 32'd0);
    chk("mid_rst_err", {29'd0, err, err_code}, 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    do_req(2'd3, 6'd5, 10, lat);
    chk("post_rst_lat", lat, 32'd2);
    burst(2'd3, 5, 0, 5, 5, 1'b1);
    drain(5, 40);
    chk("post_rst_empty", {31'd0, rx_valid}, 32'd0);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
